// File: rtl/lcd_cfg_sequencer.sv
// lcd_cfg_sequencer: AHB-Lite write master that programs the LCD drive
// register block from a snapshotted configuration vector and launches frames,
// optionally re-launching on every frame completion reported by the drive.
module lcd_cfg_sequencer #(
    parameter int                W_ADDR       = 32,
    parameter int                W_DATA       = 32,
    parameter int                W_SIZE       = 12,
    parameter int                W_DELAY      = 12,
    parameter int                W_FRAME_SIZE = 25,
    parameter int                IMG_PIX_W    = 8,
    parameter logic [W_ADDR-1:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    go,
    input  logic                    loop_en,
    input  logic                    frame_done,
    input  logic [W_SIZE-1:0]       cfg_width,
    input  logic [W_SIZE-1:0]       cfg_height,
    input  logic [W_DELAY-1:0]      cfg_start_up_delay,
    input  logic [W_DELAY-1:0]      cfg_vsync_cycle,
    input  logic [W_DELAY-1:0]      cfg_vsync_delay,
    input  logic [W_DELAY-1:0]      cfg_hsync_delay,
    input  logic [W_DELAY-1:0]      cfg_frame_trans_delay,
    input  logic [W_FRAME_SIZE-1:0] cfg_data_count,
    input  logic                    cfg_br_mode,
    input  logic [IMG_PIX_W-1:0]    cfg_br_value,
    output logic [W_ADDR-1:0]       HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [W_DATA-1:0]       HWDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic                    busy,
    output logic                    cfg_done,
    output logic                    err,
    output logic [15:0]             frame_cnt
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] LAST_IDX      = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WAIT_FRAME,
        S_ERR
    } state_t;

    state_t                  state_q;
    logic [3:0]              idx_q;
    logic [W_ADDR-1:0]       haddr_q;
    logic [1:0]              htrans_q;
    logic                    hwrite_q;
    logic [W_DATA-1:0]       hwdata_q;
    logic                    busy_q;
    logic                    cfg_done_q;
    logic                    err_q;
    logic [15:0]             frame_cnt_q;

    // Shadow copy of the configuration vector, frozen for the whole sequence
    logic [W_SIZE-1:0]       width_q;
    logic [W_SIZE-1:0]       height_q;
    logic [W_DELAY-1:0]      start_up_delay_q;
    logic [W_DELAY-1:0]      vsync_cycle_q;
    logic [W_DELAY-1:0]      vsync_delay_q;
    logic [W_DELAY-1:0]      hsync_delay_q;
    logic [W_DELAY-1:0]      frame_trans_delay_q;
    logic [W_FRAME_SIZE-1:0] data_count_q;
    logic                    br_mode_q;
    logic [IMG_PIX_W-1:0]    br_value_q;

    logic                    snap_d;
    logic [W_DATA-1:0]       wdata_d;

    // Register offsets are word-spaced in write order, so index*4 is the offset.
    function automatic logic [W_ADDR-1:0] reg_addr(input logic [3:0] idx);
        reg_addr = BASE_ADDR + W_ADDR'({idx, 2'b00});
    endfunction

    // A snapshot is taken exactly when a new sequence is launched.
    always_comb begin
        snap_d = 1'b0;
        if ((state_q == S_IDLE || state_q == S_ERR) && go)
            snap_d = 1'b1;
        else if (state_q == S_WAIT_FRAME && frame_done && loop_en)
            snap_d = 1'b1;
    end

    // Capture configuration inputs into the shadow registers on launch.
    always_ff @(posedge HCLK) begin
        if (snap_d) begin
            width_q             <= cfg_width;
            height_q            <= cfg_height;
            start_up_delay_q    <= cfg_start_up_delay;
            vsync_cycle_q       <= cfg_vsync_cycle;
            vsync_delay_q       <= cfg_vsync_delay;
            hsync_delay_q       <= cfg_hsync_delay;
            frame_trans_delay_q <= cfg_frame_trans_delay;
            data_count_q        <= cfg_data_count;
            br_mode_q           <= cfg_br_mode;
            br_value_q          <= cfg_br_value;
        end
    end

    // Select the zero-extended write data for the current register index.
    always_comb begin
        wdata_d = '0;
        case (idx_q)
            4'd0:    wdata_d = W_DATA'(width_q);
            4'd1:    wdata_d = W_DATA'(height_q);
            4'd2:    wdata_d = W_DATA'(start_up_delay_q);
            4'd3:    wdata_d = W_DATA'(vsync_cycle_q);
            4'd4:    wdata_d = W_DATA'(vsync_delay_q);
            4'd5:    wdata_d = W_DATA'(hsync_delay_q);
            4'd6:    wdata_d = W_DATA'(frame_trans_delay_q);
            4'd7:    wdata_d = W_DATA'(data_count_q);
            4'd8:    wdata_d = W_DATA'(br_mode_q);
            4'd9:    wdata_d = W_DATA'(br_value_q);
            4'd10:   wdata_d = W_DATA'(1);
            default: wdata_d = '0;
        endcase
    end

    // Sequencer FSM with all bus and status outputs registered.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            cfg_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (go) begin
                        err_q    <= 1'b0;
                        idx_q    <= 4'd0;
                        state_q  <= S_ADDR;
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= 1'b1;
                        haddr_q  <= reg_addr(4'd0);
                        busy_q   <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        state_q  <= S_DATA;
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= wdata_d;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err_q    <= 1'b1;
                            state_q  <= S_ERR;
                            hwrite_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end else if (idx_q != LAST_IDX) begin
                            idx_q    <= idx_q + 4'd1;
                            state_q  <= S_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= reg_addr(idx_q + 4'd1);
                        end else begin
                            cfg_done_q <= 1'b1;
                            hwrite_q   <= 1'b0;
                            if (loop_en) begin
                                state_q <= S_WAIT_FRAME;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                S_WAIT_FRAME: begin
                    // Frames are counted even when loop_en drops the same cycle.
                    if (frame_done)
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    if (!loop_en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (frame_done) begin
                        idx_q    <= 4'd0;
                        state_q  <= S_ADDR;
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= 1'b1;
                        haddr_q  <= reg_addr(4'd0);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    htrans_q <= HTRANS_IDLE;
                    hwrite_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HWDATA    = hwdata_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lcd_cfg_sequencer.sv
// Testbench for lcd_cfg_sequencer: scoreboard of expected register writes,
// scenario tasks for timing, wait states, bus error, looping and reset.
module tb_lcd_cfg_sequencer;

    localparam logic [31:0] BASE = 32'h4000_1000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        go = 1'b0;
    logic        loop_en = 1'b0;
    logic        frame_done = 1'b0;
    logic [11:0] cfg_width = 12'd768;
    logic [11:0] cfg_height = 12'd512;
    logic [11:0] cfg_start_up_delay = 12'd100;
    logic [11:0] cfg_vsync_cycle = 12'd3;
    logic [11:0] cfg_vsync_delay = 12'd3;
    logic [11:0] cfg_hsync_delay = 12'd160;
    logic [11:0] cfg_frame_trans_delay = 12'd200;
    logic [24:0] cfg_data_count = 25'd196608;
    logic        cfg_br_mode = 1'b1;
    logic [7:0]  cfg_br_value = 8'd100;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        busy;
    logic        cfg_done;
    logic        err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] ea, ed;
    logic [31:0] cur_addr = '0;
    bit          dphase = 0;
    int          ws = 0;
    int          wcnt = 0;
    bit          err_en = 0;
    logic [31:0] err_addr = '0;
    logic [15:0] fmodel = 16'd0;

    lcd_cfg_sequencer #(.BASE_ADDR(BASE)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .go(go), .loop_en(loop_en),
        .frame_done(frame_done),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_start_up_delay(cfg_start_up_delay), .cfg_vsync_cycle(cfg_vsync_cycle),
        .cfg_vsync_delay(cfg_vsync_delay), .cfg_hsync_delay(cfg_hsync_delay),
        .cfg_frame_trans_delay(cfg_frame_trans_delay), .cfg_data_count(cfg_data_count),
        .cfg_br_mode(cfg_br_mode), .cfg_br_value(cfg_br_value),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .busy(busy), .cfg_done(cfg_done), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Slave model: wait states on data phases and optional error response.
    always @(posedge HCLK) begin
        #1;
        if (dphase && wcnt < ws) begin
            HREADY = 1'b0;
            wcnt++;
        end else begin
            HREADY = 1'b1;
            wcnt = 0;
        end
        HRESP = dphase && err_en && (cur_addr == err_addr);
    end

    // Bus monitor: every completed write is popped from the scoreboard and compared.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dphase = 0;
        end else begin
            if (dphase && HREADY) begin
                dphase = 0;
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h required=no_write", cur_addr, HWDATA);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    if (cur_addr !== ea || HWDATA !== ed) begin
                        failures++;
                        $display("FAIL write_beat actual addr=%h data=%h required addr=%h data=%h",
                                 cur_addr, HWDATA, ea, ed);
                    end
                end
            end
            if (HTRANS == 2'b10 && HREADY) begin
                cur_addr = HADDR;
                dphase = 1;
            end
        end
    end

    // Push the first n writes a sequence launched now should produce.
    task automatic push_seq(input int n);
        logic [31:0] v[12];
        v[0] = 32'(cfg_width);            v[1] = 32'(cfg_height);
        v[2] = 32'(cfg_start_up_delay);   v[3] = 32'(cfg_vsync_cycle);
        v[4] = 32'(cfg_vsync_delay);      v[5] = 32'(cfg_hsync_delay);
        v[6] = 32'(cfg_frame_trans_delay); v[7] = 32'(cfg_data_count);
        v[8] = 32'(cfg_br_mode);          v[9] = 32'(cfg_br_value);
        v[10] = 32'd1;                    v[11] = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(v[i]);
        end
    endtask

    // One-cycle go pulse; n0 is the cycle index of the edge that samples it.
    task automatic pulse_go(output int n0);
        @(posedge HCLK); #1 go = 1'b1;
        @(posedge HCLK); #1;
        n0 = cyc;
        go = 1'b0;
    endtask

    // One-cycle frame_done pulse.
    task automatic pulse_frame;
        @(posedge HCLK); #1 frame_done = 1'b1;
        @(posedge HCLK); #1 frame_done = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int at_cyc, output bit ok);
        ok = 0;
        at_cyc = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge HCLK);
            if (cfg_done === 1'b1) begin
                ok = 1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checks++;
        if ({HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST, busy, cfg_done, err, frame_cnt} !==
            {2'b00, 32'h0, 32'h0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset_values actual htrans=%b haddr=%h hwdata=%h hwrite=%b hsize=%b hburst=%b busy=%b done=%b err=%b fcnt=%0d required all reset",
                     HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST, busy, cfg_done, err, frame_cnt);
        end
        #2 HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);
    endtask

    task automatic test_basic(input int wstates, input int lat_req, input string nm);
        int n0, c;
        bit ok;
        ws = wstates;
        push_seq(12);
        pulse_go(n0);
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== BASE || busy !== 1'b1 || HWRITE !== 1'b1) begin
            failures++;
            $display("FAIL %s_first_nonseq actual htrans=%b haddr=%h busy=%b hwrite=%b required 10 %h 1 1",
                     nm, HTRANS, HADDR, busy, HWRITE, BASE);
        end
        wait_done(400, c, ok);
        checks++;
        if (!ok || (c - n0 + 1) != lat_req) begin
            failures++;
            $display("FAIL %s_cfg_done_latency actual=%0d found=%0d required=%0d", nm, c - n0 + 1, ok, lat_req);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_after actual=%b required=0", nm, busy);
        end
        @(negedge HCLK);
        checks++;
        if (cfg_done !== 1'b0 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL %s_done_pulse actual done=%b pending=%0d required done=0 pending=0",
                     nm, cfg_done, exp_addr.size());
        end
        ws = 0;
    endtask

    task automatic test_bus_error;
        int n0, c;
        bit ok;
        bit idle_ok;
        err_en = 1;
        err_addr = BASE + 32'h14;
        push_seq(6);
        pulse_go(n0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (err === 1'b1) begin ok = 1; break; end
        end
        checks++;
        if (!ok || busy !== 1'b0) begin
            failures++;
            $display("FAIL error_flag actual err_seen=%0d busy=%b required err=1 busy=0", ok, busy);
        end
        idle_ok = 1;
        repeat (10) begin
            @(negedge HCLK);
            if (HTRANS !== 2'b00 || err !== 1'b1) idle_ok = 0;
        end
        checks++;
        if (!idle_ok || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL error_idle actual idle_ok=%0d pending=%0d required idle_ok=1 pending=0",
                     idle_ok, exp_addr.size());
        end
        err_en = 0;
        push_seq(12);
        pulse_go(n0);
        @(negedge HCLK);
        checks++;
        if (err !== 1'b0 || HTRANS !== 2'b10) begin
            failures++;
            $display("FAIL error_restart actual err=%b htrans=%b required err=0 htrans=10", err, HTRANS);
        end
        wait_done(200, c, ok);
        checks++;
        if (!ok || (c - n0 + 1) != 25 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL error_reissue actual latency=%0d pending=%0d required latency=25 pending=0",
                     c - n0 + 1, exp_addr.size());
        end
    endtask

    task automatic test_loop;
        int n0, c;
        bit ok;
        bit quiet;
        loop_en = 1'b1;
        push_seq(12);
        pulse_go(n0);
        wait_done(200, c, ok);
        @(negedge HCLK);
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL loop_wait_frame actual done=%0d busy=%b required done=1 busy=1", ok, busy);
        end
        for (int f = 0; f < 3; f++) begin
            if (f == 1) cfg_br_value = 8'd50;
            push_seq(12);
            pulse_frame();
            fmodel = fmodel + 16'd1;
            @(negedge HCLK);
            checks++;
            if (HTRANS !== 2'b10 || HADDR !== BASE) begin
                failures++;
                $display("FAIL loop_relaunch_%0d actual htrans=%b haddr=%h required 10 %h", f, HTRANS, HADDR, BASE);
            end
            wait_done(200, c, ok);
            checks++;
            if (!ok || exp_addr.size() != 0) begin
                failures++;
                $display("FAIL loop_sequence_%0d actual done=%0d pending=%0d required done=1 pending=0",
                         f, ok, exp_addr.size());
            end
        end
        @(negedge HCLK);
        checks++;
        if (frame_cnt !== fmodel) begin
            failures++;
            $display("FAIL loop_frame_cnt actual=%0d required=%0d", frame_cnt, fmodel);
        end
        // go while waiting for a frame must not start anything
        pulse_go(n0);
        quiet = 1;
        repeat (8) begin
            @(negedge HCLK);
            if (HTRANS !== 2'b00 || busy !== 1'b1) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL go_in_wait_frame actual quiet=0 required quiet=1");
        end
        // go and a config change mid-sequence must not disturb the snapshot
        push_seq(12);
        pulse_frame();
        fmodel = fmodel + 16'd1;
        repeat (6) @(posedge HCLK);
        cfg_br_value = 8'd7;
        pulse_go(n0);
        wait_done(200, c, ok);
        checks++;
        if (!ok || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL go_mid_sequence actual done=%0d pending=%0d required done=1 pending=0", ok, exp_addr.size());
        end
        // frame_done coinciding with loop_en=0: counted, then idle
        @(posedge HCLK); #1;
        loop_en = 1'b0;
        frame_done = 1'b1;
        @(posedge HCLK); #1 frame_done = 1'b0;
        fmodel = fmodel + 16'd1;
        @(negedge HCLK);
        checks++;
        if (frame_cnt !== fmodel || busy !== 1'b0 || HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL loop_exit actual fcnt=%0d busy=%b htrans=%b required fcnt=%0d busy=0 htrans=00",
                     frame_cnt, busy, HTRANS, fmodel);
        end
        cfg_br_value = 8'd100;
    endtask

    task automatic test_reset_mid_transfer;
        int n0, c;
        bit ok;
        bit found;
        bit quiet;
        push_seq(5);
        pulse_go(n0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge HCLK); #1;
            if (dphase && cur_addr == BASE + 32'h14) begin found = 1; break; end
        end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (!found || {HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST, busy, cfg_done, err, frame_cnt} !==
            {2'b00, 32'h0, 32'h0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL async_reset actual found=%0d htrans=%b haddr=%h hwdata=%h hwrite=%b busy=%b fcnt=%0d required reset values",
                     found, HTRANS, HADDR, HWDATA, HWRITE, busy, frame_cnt);
        end
        fmodel = 16'd0;
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        quiet = 1;
        repeat (10) begin
            @(negedge HCLK);
            if (HTRANS !== 2'b00 || busy !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL reset_no_resume actual quiet=%0d pending=%0d required quiet=1 pending=0",
                     quiet, exp_addr.size());
        end
        push_seq(12);
        pulse_go(n0);
        wait_done(200, c, ok);
        checks++;
        if (!ok || (c - n0 + 1) != 25 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL reset_restart actual latency=%0d pending=%0d required latency=25 pending=0",
                     c - n0 + 1, exp_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, 25, "basic");
        test_basic(2, 49, "wait_states");
        test_bus_error();
        test_loop();
        test_reset_mid_transfer();
        repeat (3) @(posedge HCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
